adsr_envelope: RTL
==================

Name: adsr_envelope

Overview:
- Amplitude-envelope stage between note_player and audio_to_pwm_conversion.
- Takes note_player's signed 16-bit sample stream and a note gate, and runs an Attack/Decay/Sustain/Release state machine producing an 8-bit envelope level.
- Scales each incoming sample by that level and forwards the shaped signed 16-bit sample, with a valid strobe, to the PWM conversion stage.

Parameters:
- RATE_DIV, 4: input samples per envelope tick. Legal range 1..65535.
- ATTACK_STEP, 16: level increment per tick in ATTACK.
- DECAY_STEP, 8: level decrement per tick in DECAY.
- RELEASE_STEP, 4: level decrement per tick in RELEASE (linear mode).
- RELEASE_SHIFT, 3: right-shift used in exponential release (optional feature only).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- gate  in  1  note held (level-sensitive).
- sustain_level  in  8  sustain amplitude, 0..255.
- sample_in  in  16  signed sample from note_player.
- sample_in_valid  in  1  one-cycle strobe; sample_in is valid this cycle.
- sample_out  out  16  signed scaled sample to audio_to_pwm_conversion.
- sample_out_valid  out  1  one-cycle strobe, registered.
- env_level  out  8  current envelope level.
- env_state  out  3  state encoding: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- env_active  out  1  high when env_state != IDLE.

Behaviour:
- Reset (synchronous, active-high, clk rising edge):
  - state IDLE; env_level 0; prescaler 0; gate_q 0.
  - sample_out 0x0000; sample_out_valid 0; env_active 0.
  - Reset mid-note aborts immediately; no release tail.
- Gate edge detect:
  - gate_q registers gate each cycle.
  - rise = gate & ~gate_q; fall = ~gate & gate_q.
- Prescaler:
  - Counts sample_in_valid strobes 0..RATE_DIV-1, then wraps.
  - tick = sample_in_valid && prescaler == RATE_DIV-1.
  - Free-running; not cleared by gate edges.
- State transitions are evaluated every cycle; level changes only on tick. Priority: reset > gate edge > tick.
  - IDLE: rise -> ATTACK.
  - ATTACK, rise (no effect since already attacking). On tick: level + ATTACK_STEP, saturate at 255; on reaching 255 -> DECAY.
  - DECAY, on tick: if level - DECAY_STEP <= sustain_level (underflow included), level = sustain_level and -> SUSTAIN; else subtract. If sustain_level > level, clamp upward to sustain_level and -> SUSTAIN.
  - SUSTAIN, on tick: level = sustain_level, so a changed sustain_level is tracked at tick rate.
  - ATTACK, DECAY or SUSTAIN, fall -> RELEASE.
  - RELEASE, on tick: if level <= RELEASE_STEP, level = 0 and -> IDLE; else subtract RELEASE_STEP.
  - RELEASE, rise -> ATTACK from the current level, with no reset to 0 (click-free retrigger).
- Simultaneous events: a gate edge and a tick in the same cycle take the state change only; env_level is unchanged that cycle and that tick's step is dropped.
- Datapath:
  - On sample_in_valid, product = signed(sample_in) * signed({1'b0, env_level}), 25 bits.
  - sample_out = product[23:8], i.e. arithmetic >>> 8.
  - Uses the env_level register value before this cycle's update.
  - Latency is 1 cycle: sample_out and sample_out_valid register on the cycle after sample_in_valid.
  - sample_out holds its value between strobes; sample_out_valid is high exactly one cycle per input strobe.
  - Level 255 gives gain 255/256; level 0 gives 0x0000.
- sample_in_valid may be asserted back-to-back every cycle; there is no backpressure.

Optional Feature:
- Macro ADSR_EXP_RELEASE_EN.
- Defined: RELEASE tick subtracts max(level >> RELEASE_SHIFT, 1), giving an exponential-style tail. Reaching 0 -> IDLE.
- Undefined: linear RELEASE_STEP decrement as above.
- RELEASE_SHIFT is unused when the macro is undefined.

Test Plan:
- Reset, then 10 strobes with sample_in=0x4000 and gate=0 -> sample_out=0x0000 each cycle after a strobe; env_state=0; env_active=0.
- Attack, defaults: gate=1 and continuous strobes -> env_state=1; level 240 after 60 strobes, 255 after 64; then env_state=2.
- Decay, sustain_level=128: 15 ticks give level 135, the 16th clamps to 128 -> env_state=3. Then sample_in=0x4000 -> sample_out=0x2000 one cycle after the strobe.
- Gain at level 255 with sample_in=0xC000 (-16384) -> sample_out=0xC040 (-16320). A strobe with no gate edge -> sample_out_valid high exactly one cycle, at latency 1.
- Release and retrigger, level 128: fall -> RELEASE with 0 after 32 ticks, then IDLE. In a separate run, rise at level 64 in RELEASE -> ATTACK continues 64, 80, 96...; a gate edge coinciding with a tick leaves the level unchanged that cycle.
- With ADSR_EXP_RELEASE_EN, level 128, shift 3: release ticks give 112, 98, 86... and reach 0, then IDLE. Reset asserted mid-ATTACK -> next cycle level 0, IDLE, sample_out 0x0000.

Source files
------------

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: gate-driven A/D/S/R level scaling a 16-bit sample stream.
// Build with ADSR_EXP_RELEASE_EN defined for an exponential-style release tail.
module adsr_envelope #(
    parameter int RATE_DIV      = 4,
    parameter int ATTACK_STEP   = 16,
    parameter int DECAY_STEP    = 8,
    parameter int RELEASE_STEP  = 4,
    parameter int RELEASE_SHIFT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gate,
    input  logic [7:0]  sustain_level,
    input  logic [15:0] sample_in,
    input  logic        sample_in_valid,
    output logic [15:0] sample_out,
    output logic        sample_out_valid,
    output logic [7:0]  env_level,
    output logic [2:0]  env_state,
    output logic        env_active
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ATTACK  = 3'd1;
    localparam logic [2:0] DECAY   = 3'd2;
    localparam logic [2:0] SUSTAIN = 3'd3;
    localparam logic [2:0] RELEASE = 3'd4;

`ifdef ADSR_EXP_RELEASE_EN
    localparam bit EXP_REL = 1'b1;
`else
    localparam bit EXP_REL = 1'b0;
`endif

    localparam logic [15:0] PRE_MAX = 16'(RATE_DIV - 1);
    localparam logic [8:0]  A_STEP  = 9'(ATTACK_STEP);
    localparam logic [9:0]  D_STEP  = 10'(DECAY_STEP);
    localparam logic [7:0]  R_STEP  = 8'(RELEASE_STEP);

    logic [2:0]  state, state_n;
    logic [7:0]  level, level_n;
    logic [15:0] prescaler;
    logic        gate_q;
    logic        rise, fall, edge_any, tick;

    logic [8:0]  att_sum;
    logic [9:0]  dec_diff;
    logic [7:0]  rel_shr, rel_dec;

    logic signed [24:0] product;
    logic               unused_bits;

    assign rise     = gate & ~gate_q;
    assign fall     = ~gate & gate_q;
    assign edge_any = rise | fall;
    assign tick     = sample_in_valid && (prescaler == PRE_MAX);

    assign att_sum  = {1'b0, level} + A_STEP;
    assign dec_diff = {2'b00, level} - D_STEP;
    assign rel_shr  = level >> RELEASE_SHIFT;

    // Release decrement: fixed step, or level-proportional with a floor of 1.
    always_comb begin
        rel_dec = R_STEP;
        if (EXP_REL) begin
            rel_dec = (rel_shr == 8'd0) ? 8'd1 : rel_shr;
        end
    end

    // Next state / level: gate edges pre-empt any tick in the same cycle.
    always_comb begin
        state_n = state;
        level_n = level;
        case (state)
            IDLE: begin
                if (rise) state_n = ATTACK;
            end
            ATTACK: begin
                if (fall) begin
                    state_n = RELEASE;
                end else if (!edge_any && tick) begin
                    if (att_sum >= 9'd255) begin
                        level_n = 8'd255;
                        state_n = DECAY;
                    end else begin
                        level_n = att_sum[7:0];
                    end
                end
            end
            DECAY: begin
                if (fall) begin
                    state_n = RELEASE;
                end else if (!edge_any && tick) begin
                    if (dec_diff[9] || dec_diff[7:0] <= sustain_level) begin
                        level_n = sustain_level;
                        state_n = SUSTAIN;
                    end else begin
                        level_n = dec_diff[7:0];
                    end
                end
            end
            SUSTAIN: begin
                if (fall) begin
                    state_n = RELEASE;
                end else if (!edge_any && tick) begin
                    level_n = sustain_level;
                end
            end
            RELEASE: begin
                if (rise) begin
                    state_n = ATTACK;
                end else if (!edge_any && tick) begin
                    if (level <= rel_dec) begin
                        level_n = 8'd0;
                        state_n = IDLE;
                    end else begin
                        level_n = level - rel_dec;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                level_n = 8'd0;
            end
        endcase
    end

    // Envelope registers, gate history and the free-running sample prescaler.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            level     <= 8'd0;
            prescaler <= 16'd0;
            gate_q    <= 1'b0;
        end else begin
            state  <= state_n;
            level  <= level_n;
            gate_q <= gate;
            if (sample_in_valid) begin
                prescaler <= (prescaler == PRE_MAX) ? 16'd0 : prescaler + 16'd1;
            end
        end
    end

    assign product = $signed({{9{sample_in[15]}}, sample_in})
                   * $signed({17'd0, level});
    assign unused_bits = ^{product[24], product[7:0]};

    // Scaled sample, one cycle after the strobe, using the pre-update level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_out       <= 16'h0000;
            sample_out_valid <= 1'b0;
        end else begin
            sample_out_valid <= sample_in_valid;
            if (sample_in_valid) begin
                sample_out <= product[23:8];
            end
        end
    end

    assign env_level  = level;
    assign env_state  = state;
    assign env_active = (state != IDLE);

endmodule
